// File: rtl/module_disp_scanner.sv
// rtl/module_disp_scanner.sv - N-digit multiplexed 7-segment scanner with dead-time blanking and per-frame snapshot (optional LEADING_ZERO_BLANK_EN)
module module_disp_scanner #(
  parameter int CLK_FREQ_HZ       = 27_000_000,
  parameter int SCAN_HZ           = 1000,
  parameter int N_DIGITS          = 4,
  parameter int BLANK_CYCLES      = 27,
  parameter bit ANODE_ACTIVE_HIGH = 1'b1,
  parameter bit SEG_ACTIVE_HIGH   = 1'b0
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic [4*N_DIGITS-1:0]                              digits_i,
  input  logic [N_DIGITS-1:0]                                dp_i,
  input  logic [N_DIGITS-1:0]                                en_i,
  output logic [N_DIGITS-1:0]                                an_o,
  output logic [6:0]                                         seg_o,
  output logic                                               dp_o,
  output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] digit_idx_o,
  output logic                                               frame_o
);

  localparam int DWELL = CLK_FREQ_HZ / SCAN_HZ;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [N_DIGITS-1:0] AN_OFF  = ANODE_ACTIVE_HIGH ? '0 : '1;
  localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_HIGH ? 7'h00 : 7'h7F;
  localparam logic                DP_OFF  = !SEG_ACTIVE_HIGH;

  // Reject parameter sets that cannot produce a meaningful scan
  if (DWELL < 1) begin : g_bad_dwell
    $error("module_disp_scanner: DWELL must be at least 1");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= DWELL) begin : g_bad_blank
    $error("module_disp_scanner: BLANK_CYCLES must be in 0..DWELL-1");
  end
  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_ndig
    $error("module_disp_scanner: N_DIGITS must be in 1..8");
  end

  // Active-high gfedcba pattern for a hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [4*N_DIGITS-1:0] snap_d, snap_d_n;
  logic [N_DIGITS-1:0]   snap_dp, snap_dp_n;
  logic [N_DIGITS-1:0]   snap_en, snap_en_n;
  logic                  first;
  logic                  load;
  logic [N_DIGITS-1:0]   eff_en;
  logic                  lit;
  logic [3:0]            cur_digit;
  logic [N_DIGITS-1:0]   an_n;
  logic [6:0]            seg_n;
  logic                  dp_n;

  // Effective enables captured into the snapshot (optionally with leading zeros blanked)
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic supp;
    eff_en = en_i;
    supp   = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (en_i[i]) begin
        if (supp && digits_i[4*i +: 4] == 4'h0 && !dp_i[i]) eff_en[i] = 1'b0;
        else supp = 1'b0;
      end
    end
  end
`else
  always_comb begin
    eff_en = en_i;
  end
`endif

  // Next-state of counters and snapshot, then the output levels those next values imply
  always_comb begin
    load      = first || ((cnt == CNT_W'(DWELL - 1)) && (idx == IDX_W'(N_DIGITS - 1)));
    cnt_n     = cnt + CNT_W'(1);
    idx_n     = idx;
    if (first) begin
      cnt_n = '0;
      idx_n = '0;
    end else if (cnt == CNT_W'(DWELL - 1)) begin
      cnt_n = '0;
      idx_n = (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
    snap_d_n  = load ? digits_i : snap_d;
    snap_dp_n = load ? dp_i : snap_dp;
    snap_en_n = load ? eff_en : snap_en;
    cur_digit = snap_d_n[idx_n*4 +: 4];
    lit       = (32'(cnt_n) >= BLANK_CYCLES) && snap_en_n[idx_n];
    an_n      = lit ? (N_DIGITS'(1) << idx_n) : '0;
    an_n      = ANODE_ACTIVE_HIGH ? an_n : ~an_n;
    seg_n     = lit ? hex7(cur_digit) : 7'h00;
    seg_n     = SEG_ACTIVE_HIGH ? seg_n : ~seg_n;
    dp_n      = lit && snap_dp_n[idx_n];
    dp_n      = SEG_ACTIVE_HIGH ? dp_n : !dp_n;
  end

  // Counters, snapshot and registered pin drives all advance on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      snap_d  <= '0;
      snap_dp <= '0;
      snap_en <= '0;
      first   <= 1'b1;
      an_o    <= AN_OFF;
      seg_o   <= SEG_OFF;
      dp_o    <= DP_OFF;
      frame_o <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      idx     <= idx_n;
      snap_d  <= snap_d_n;
      snap_dp <= snap_dp_n;
      snap_en <= snap_en_n;
      first   <= 1'b0;
      an_o    <= an_n;
      seg_o   <= seg_n;
      dp_o    <= dp_n;
      frame_o <= load;
    end
  end

  assign digit_idx_o = idx;

endmodule

// File: tb/tb_module_disp_scanner.sv
// tb/tb_module_disp_scanner.sv - randomized self-checking bench for module_disp_scanner against a frame/slot arithmetic model
module tb_module_disp_scanner;

  localparam int N  = 4;
  localparam int DW = 10;
  localparam int BL = 2;
  localparam int FR = N * DW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  en = 4'h0;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [1:0]  digit_idx_o;
  logic        frame_o;

  int checks = 0;
  int errors = 0;

  // Model state: e = edges since reset release (-1 while in reset)
  int          e = -1;
  logic [15:0] m_d;
  logic [3:0]  m_dp;
  logic [3:0]  m_en;
  logic [3:0]  x_an;
  logic [6:0]  x_seg;
  logic        x_dp;
  logic        x_frame;
  logic [1:0]  x_idx;
  logic [6:0]  dec_tab [16];

  always #5 clk = ~clk;

  module_disp_scanner #(
    .CLK_FREQ_HZ(1000), .SCAN_HZ(100), .N_DIGITS(N), .BLANK_CYCLES(BL),
    .ANODE_ACTIVE_HIGH(1'b1), .SEG_ACTIVE_HIGH(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits_i(digits), .dp_i(dp), .en_i(en),
    .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o), .digit_idx_o(digit_idx_o), .frame_o(frame_o)
  );

  // Which digits are visible in a frame, from the enable and leading-zero rules
  function automatic logic [3:0] vis_en(input logic [15:0] d, input logic [3:0] p, input logic [3:0] ena);
    logic [3:0] r;
    r = ena;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 3; i >= 1; i--) begin
      bit no_visible_above;
      no_visible_above = 1'b1;
      for (int j = i + 1; j < 4; j++) if (r[j]) no_visible_above = 1'b0;
      if (no_visible_above && d[4*i +: 4] == 4'h0 && !p[i]) r[i] = 1'b0;
    end
`endif
    return r;
  endfunction

  // Advance one clock and compute what the pins must show after this edge
  task automatic tick();
    int s, c;
    bit lit;
    @(posedge clk);
    if (!rst_n) begin
      e = -1;
      x_an = 4'h0; x_seg = 7'h7F; x_dp = 1'b1; x_frame = 1'b0; x_idx = 2'd0;
    end else begin
      e++;
      if (e % FR == 0) begin
        m_d = digits; m_dp = dp; m_en = vis_en(digits, dp, en);
      end
      s = (e / DW) % N;
      c = e % DW;
      lit = (c >= BL) && m_en[s];
      x_an    = lit ? 4'(1 << s) : 4'h0;
      x_seg   = lit ? ~dec_tab[m_d[4*s +: 4]] : 7'h7F;
      x_dp    = lit ? ~m_dp[s] : 1'b1;
      x_frame = (e % FR == 0);
      x_idx   = s[1:0];
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 8; k++) begin
      digits = 16'($urandom); dp = 4'($urandom); en = 4'($urandom);
      tick();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o, digit_idx_o} !== {4'h0, 7'h7F, 1'b1, 1'b0, 2'd0}) begin
        errors++;
        $display("FAIL reset k=%0d got an=%b seg=%h dp=%b fr=%b idx=%0d", k, an_o, seg_o, dp_o, frame_o, digit_idx_o);
      end
    end
  endtask

  task automatic test_scan();
    int lit_cnt [4];
    int frames;
    lit_cnt = '{0, 0, 0, 0};
    frames = 0;
    digits = 16'h1234; en = 4'hF; dp = 4'h0;
    rst_n = 1'b1;
    for (int k = 0; k < 2 * FR; k++) begin
      tick();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o, digit_idx_o} !== {x_an, x_seg, x_dp, x_frame, x_idx}) begin
        errors++;
        $display("FAIL scan e=%0d got an=%b seg=%h dp=%b fr=%b idx=%0d want an=%b seg=%h dp=%b fr=%b idx=%0d",
                 e, an_o, seg_o, dp_o, frame_o, digit_idx_o, x_an, x_seg, x_dp, x_frame, x_idx);
      end
      for (int b = 0; b < 4; b++) if (an_o[b]) lit_cnt[b]++;
      if (frame_o) frames++;
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (lit_cnt[b] != 2 * (DW - BL)) begin
        errors++;
        $display("FAIL scan_lit digit=%0d got %0d want %0d", b, lit_cnt[b], 2 * (DW - BL));
      end
    end
    checks++;
    if (frames != 2) begin
      errors++;
      $display("FAIL scan_frames got %0d want 2", frames);
    end
  endtask

  task automatic test_tearfree();
    int change_e;
    change_e = -1000;
    for (int k = 0; k < 2 * FR + 20; k++) begin
      tick();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o, digit_idx_o} !== {x_an, x_seg, x_dp, x_frame, x_idx}) begin
        errors++;
        $display("FAIL tearfree e=%0d got an=%b seg=%h dp=%b fr=%b idx=%0d want an=%b seg=%h dp=%b fr=%b idx=%0d",
                 e, an_o, seg_o, dp_o, frame_o, digit_idx_o, x_an, x_seg, x_dp, x_frame, x_idx);
      end
      if (e == change_e + 13) begin
        checks++;
        if (seg_o !== ~7'h06) begin
          errors++;
          $display("FAIL tearfree_old got seg=%h want %h", seg_o, ~7'h06);
        end
      end
      if (e == change_e + 53) begin
        checks++;
        if (seg_o !== ~7'h77) begin
          errors++;
          $display("FAIL tearfree_new got seg=%h want %h", seg_o, ~7'h77);
        end
      end
      if (e % FR == 22 && change_e < 0) begin
        digits = 16'hABCD;
        change_e = e;
      end
    end
  endtask

  task automatic test_enable_dp();
    int dp_lit, dark_lit, guard;
    en = 4'b0101; dp = 4'b0001;
    dp_lit = 0; dark_lit = 0; guard = 0;
    do begin
      tick();
      guard++;
      checks++;
      if ({an_o, seg_o, dp_o, frame_o, digit_idx_o} !== {x_an, x_seg, x_dp, x_frame, x_idx}) begin
        errors++;
        $display("FAIL endp_pre e=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", e, an_o, seg_o, dp_o, x_an, x_seg, x_dp);
      end
    end while (e % FR != FR - 1 && guard < 2 * FR);
    for (int k = 0; k < FR; k++) begin
      tick();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o, digit_idx_o} !== {x_an, x_seg, x_dp, x_frame, x_idx}) begin
        errors++;
        $display("FAIL endp e=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", e, an_o, seg_o, dp_o, x_an, x_seg, x_dp);
      end
      if (dp_o == 1'b0) dp_lit++;
      if (an_o[1] || an_o[3]) dark_lit++;
    end
    checks++;
    if (dp_lit != DW - BL || dark_lit != 0) begin
      errors++;
      $display("FAIL endp_count got dp=%0d dark=%0d want dp=%0d dark=0", dp_lit, dark_lit, DW - BL);
    end
  endtask

  task automatic test_lzb();
    int lit_cnt [4];
    int want [4];
    int guard;
`ifdef LEADING_ZERO_BLANK_EN
    want = '{DW - BL, DW - BL, 0, 0};
`else
    want = '{DW - BL, DW - BL, DW - BL, DW - BL};
`endif
    lit_cnt = '{0, 0, 0, 0};
    digits = 16'h0070; en = 4'hF; dp = 4'h0;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (e % FR != FR - 1 && guard < 2 * FR);
    for (int k = 0; k < FR; k++) begin
      tick();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o, digit_idx_o} !== {x_an, x_seg, x_dp, x_frame, x_idx}) begin
        errors++;
        $display("FAIL lzb e=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", e, an_o, seg_o, dp_o, x_an, x_seg, x_dp);
      end
      for (int b = 0; b < 4; b++) if (an_o[b]) lit_cnt[b]++;
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (lit_cnt[b] != want[b]) begin
        errors++;
        $display("FAIL lzb_lit digit=%0d got %0d want %0d", b, lit_cnt[b], want[b]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8 * FR; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int n = 0; n < 4; n++) digits[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        dp = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      end
      tick();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o, digit_idx_o} !== {x_an, x_seg, x_dp, x_frame, x_idx}) begin
        errors++;
        $display("FAIL random e=%0d d=%h dp=%b en=%b got an=%b seg=%h dp=%b fr=%b idx=%0d want an=%b seg=%h dp=%b fr=%b idx=%0d",
                 e, m_d, m_dp, m_en, an_o, seg_o, dp_o, frame_o, digit_idx_o, x_an, x_seg, x_dp, x_frame, x_idx);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    digits = 16'h5678; en = 4'hF; dp = 4'h0;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (e % FR != 2 * DW + 5 && guard < 3 * FR);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({an_o, seg_o, dp_o, frame_o, digit_idx_o} !== {4'h0, 7'h7F, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL rstmid_async got an=%b seg=%h dp=%b fr=%b idx=%0d", an_o, seg_o, dp_o, frame_o, digit_idx_o);
    end
    for (int k = 0; k < 3; k++) begin
      digits = 16'($urandom);
      tick();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o, digit_idx_o} !== {x_an, x_seg, x_dp, x_frame, x_idx}) begin
        errors++;
        $display("FAIL rstmid_hold got an=%b seg=%h dp=%b fr=%b", an_o, seg_o, dp_o, frame_o);
      end
    end
    digits = 16'h9E0F; en = 4'hF; dp = 4'b0100;
    rst_n = 1'b1;
    for (int k = 0; k < FR + 10; k++) begin
      tick();
      checks++;
      if ({an_o, seg_o, dp_o, frame_o, digit_idx_o} !== {x_an, x_seg, x_dp, x_frame, x_idx}) begin
        errors++;
        $display("FAIL rstmid_after e=%0d got an=%b seg=%h dp=%b fr=%b idx=%0d want an=%b seg=%h dp=%b fr=%b idx=%0d",
                 e, an_o, seg_o, dp_o, frame_o, digit_idx_o, x_an, x_seg, x_dp, x_frame, x_idx);
      end
    end
  endtask

  initial begin
    dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    test_reset();
    test_scan();
    test_tearfree();
    test_enable_dp();
    test_lzb();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
